// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and the shift-add multiplier state set.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        SHL = 3'b010,
        SHR = 3'b011,
        OR  = 3'b100,
        AND = 3'b101,
        XOR = 3'b110,
        NOT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/alu_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier that borrows an external ALU's adder,
// one partial-sum step per cycle, producing a {ACC,Q} product of 2*BUS_SIZE bits.
module alu_shift_add_multiplier
    import alu_pkg::*;
#(
    parameter int unsigned BUS_SIZE = 8,
    parameter int unsigned SHAMT_P  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BUS_SIZE-1:0]     multiplicand,
    input  logic [BUS_SIZE-1:0]     multiplier,
    output logic                    ready,
    output logic                    done,
    output logic [2*BUS_SIZE-1:0]   product,
    output logic                    hi_nonzero,
    output logic [BUS_SIZE-1:0]     alu_a,
    output logic [BUS_SIZE-1:0]     alu_b,
    output logic [2:0]              alu_select,
    output logic [SHAMT_P-1:0]      alu_shamt,
    input  logic [BUS_SIZE-1:0]     alu_s,
    input  logic                    alu_carry_out
);

    localparam int unsigned PW = 2 * BUS_SIZE;

    mul_state_e             state_q, state_d;
    logic [BUS_SIZE-1:0]    acc_q, acc_d;
    logic [BUS_SIZE-1:0]    q_q, q_d;
    logic [BUS_SIZE-1:0]    m_q, m_d;
    logic [SHAMT_P-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]          prod_q, prod_d;
    logic                   hi_q, hi_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic [BUS_SIZE-1:0]    alu_b_q, alu_b_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            hi_q    <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            alu_b_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            alu_b_q <= alu_b_d;
        end
    end

    // Next-state logic; each RUN cycle shifts {carry, sum, Q} right by one
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        hi_d    = hi_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = {alu_carry_out, alu_s[BUS_SIZE-1:1]};
                q_d   = {alu_s[0], q_q[BUS_SIZE-1:1]};
                cnt_d = cnt_q + SHAMT_P'(1);
                if (cnt_q == SHAMT_P'(BUS_SIZE - 1)) begin
                    prod_d  = {acc_d, q_d};
                    hi_d    = |acc_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags and the ALU b operand are precomputed so they leave from flops
        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
        alu_b_d = q_d[0] ? m_d : '0;
    end

    assign ready      = ready_q;
    assign done       = done_q;
    assign product    = prod_q;
    assign hi_nonzero = hi_q;
    assign alu_a      = acc_q;
    assign alu_b      = alu_b_q;
    assign alu_select = 3'(ADD);
    assign alu_shamt  = '0;

endmodule
